ifetch_ctrl_32: RTL and testbench

Instruction-fetch sequencer that sits on the far side of the PC register. It consumes the current PC from the PC register's `new_addr`, reads the instruction word from instruction memory over a req/ack handshake, and presents the instruction to decode. It also computes the next PC and returns it to the PC register's `addr` input. Because the PC register has no enable, this block stalls the PC by feeding back the current PC until the instruction has issued.

---
 rtl/ifetch_ctrl_32.sv | 122 ++++++++++++
 tb/tb_ifetch_ctrl_32.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ifetch_ctrl_32.sv
// rtl/ifetch_ctrl_32.sv - instruction-fetch sequencer: PC -> imem req/ack -> decode, computes next PC
module ifetch_ctrl_32 #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] RESET_PC = 32'h00400020
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  output logic [31:0] next_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        stall_in,
  input  logic        branch_taken,
  input  logic [15:0] branch_off,
  input  logic        jump,
  input  logic [25:0] jump_tgt,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  output logic        fetch_err,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, ERR} state_e;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;

  logic        aligned;
  logic [31:0] p4;
  logic [31:0] redirect_pc;

  // The boot address lives in the PC register; it is carried here for documentation only.
  logic unused_reset_pc;
  assign unused_reset_pc = ^RESET_PC;

  assign aligned   = (pc_in[1:0] == 2'b00);
  assign p4        = pc_in + 32'd4;
  assign imem_addr = pc_in;

  always_comb begin
    if (jr)
      redirect_pc = jr_addr;
    else if (jump)
      redirect_pc = {p4[31:28], jump_tgt, 2'b00};
    else if (branch_taken)
      redirect_pc = p4 + {{14{branch_off[15]}}, branch_off, 2'b00};
    else
      redirect_pc = p4;
  end

  // The PC register has no enable, so next_pc echoes pc_in except on the issuing cycle.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    count_d  = count_q;
    imem_req = 1'b0;
    next_pc  = pc_in;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (!aligned) begin
          state_d = ERR;
        end else begin
          imem_req = 1'b1;
          if (imem_ack) begin
            instr_d = imem_rdata;
            valid_d = 1'b1;
            wait_d  = 8'd0;
            state_d = ISSUE;
          end else if (wait_q == WAIT_LAST) begin
            state_d = ERR;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
      end
      ISSUE: begin
        if (!stall_in) begin
          next_pc = redirect_pc;
          count_d = count_q + 32'd1;
          valid_d = 1'b0;
          state_d = FETCH;
        end
      end
      ERR: valid_d = 1'b0;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wait_q  <= 8'd0;
      instr_q <= 32'd0;
      valid_q <= 1'b0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign fetch_count = count_q;
  assign fetch_err   = (state_q == ERR);

endmodule

// File: tb/tb_ifetch_ctrl_32.sv
// tb/tb_ifetch_ctrl_32.sv - directed scoreboard bench for ifetch_ctrl_32
module tb_ifetch_ctrl_32;

  localparam logic [31:0] RESET_PC = 32'h00400020;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic [31:0] next_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall_in;
  logic        branch_taken;
  logic [15:0] branch_off;
  logic        jump;
  logic [25:0] jump_tgt;
  logic        jr;
  logic [31:0] jr_addr;
  logic        fetch_err;
  logic [31:0] fetch_count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] next;
  } exp_t;
  exp_t sb_q[$];

  ifetch_ctrl_32 #(.TIMEOUT(16), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .next_pc(next_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
    .stall_in(stall_in), .branch_taken(branch_taken), .branch_off(branch_off),
    .jump(jump), .jump_tgt(jump_tgt), .jr(jr), .jr_addr(jr_addr),
    .fetch_err(fetch_err), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered just after a negedge with the DUT in FETCH; leaves the DUT in the following FETCH.
  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] rdata,
                          input int waits, input int stalls,
                          input logic r_jr, input logic r_jump, input logic r_br,
                          input logic [15:0] off, input logic [25:0] tgt,
                          input logic [31:0] jra, input logic [31:0] exp_next,
                          input logic [31:0] exp_count);
    exp_t e;
    pc_in = pc;
    jr = r_jr; jump = r_jump; branch_taken = r_br;
    branch_off = off; jump_tgt = tgt; jr_addr = jra;
    stall_in = 1'b0;
    #1;
    check("imem_addr", imem_addr, pc);
    for (int w = 0; w < waits; w++) begin
      check("req_wait", 32'(imem_req), 32'd1);
      check("next_pc_fetch", next_pc, pc);
      @(negedge clk); #1;
    end
    imem_ack = 1'b1;
    imem_rdata = rdata;
    check("req_ack", 32'(imem_req), 32'd1);
    check("valid_fetch", 32'(instr_valid), 32'd0);
    e.instr = rdata;
    e.next  = exp_next;
    sb_q.push_back(e);
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = 32'hDEADBEEF;
    for (int s = 0; s < stalls; s++) begin
      stall_in = 1'b1;
      #1;
      check("valid_stall", 32'(instr_valid), 32'd1);
      check("instr_stall", instr, rdata);
      check("next_pc_stall", next_pc, pc);
      check("req_stall", 32'(imem_req), 32'd0);
      @(negedge clk);
    end
    stall_in = 1'b0;
    #1;
    check("sb_depth", 32'(sb_q.size()), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("instr_issue", instr, e.instr);
      check("valid_issue", 32'(instr_valid), 32'd1);
      check("next_pc_issue", next_pc, e.next);
      pc_in = e.next;
    end
    jr = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    @(negedge clk); #1;
    check("fetch_count", fetch_count, exp_count);
    check("valid_clear", 32'(instr_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b0; pc_in = RESET_PC; imem_ack = 1'b0; imem_rdata = 32'd0;
    stall_in = 1'b0; branch_taken = 1'b0; branch_off = 16'd0;
    jump = 1'b0; jump_tgt = 26'd0; jr = 1'b0; jr_addr = 32'd0;
    #2;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_count", fetch_count, 32'd0);
    check("rst_err", 32'(fetch_err), 32'd0);
    check("rst_next_pc", next_pc, RESET_PC);
    check("rst_addr", imem_addr, RESET_PC);
    @(negedge clk); reset = 1'b1; #1;
    check("idle_req", 32'(imem_req), 32'd0);
    @(negedge clk); #1;

    // Boot, then wait-and-stall
    do_fetch(32'h00400020, 32'h20080005, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h00400024, 32'd1);
    do_fetch(32'h00400024, 32'h8C090004, 3, 4, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h00400028, 32'd2);

    // Redirects (stalled cycle in the jump case shows redirect is held off)
    do_fetch(32'h00400030, 32'h1000FFFE, 0, 0, 0, 0, 1, 16'hFFFE, 26'h0, 32'h0, 32'h0040002C, 32'd3);
    do_fetch(32'h00400030, 32'h08100008, 0, 1, 0, 1, 0, 16'h0, 26'h0100008, 32'h0, 32'h00400020, 32'd4);
    do_fetch(32'h00400030, 32'h01000008, 0, 0, 1, 1, 1, 16'hFFFE, 26'h0100008, 32'h00400100, 32'h00400100, 32'd5);

    // Ack on the last allowed wait cycle wins over the timeout
    do_fetch(32'h00400100, 32'h00000000, 15, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h00400104, 32'd6);

    // Misaligned jr target
    do_fetch(32'h00400104, 32'h00400008, 0, 0, 1, 0, 0, 16'h0, 26'h0, 32'h00400102, 32'h00400102, 32'd7);
    check("mis_req", 32'(imem_req), 32'd0);
    check("mis_err_early", 32'(fetch_err), 32'd0);
    imem_ack = 1'b1;
    @(negedge clk); #1;
    imem_ack = 1'b0;
    check("mis_err", 32'(fetch_err), 32'd1);
    check("mis_req_err", 32'(imem_req), 32'd0);
    check("mis_valid", 32'(instr_valid), 32'd0);
    check("mis_count", fetch_count, 32'd7);

    reset = 1'b0; #1;
    check("rec_err", 32'(fetch_err), 32'd0);
    check("rec_count", fetch_count, 32'd0);
    pc_in = RESET_PC;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #1;

    // Timeout: 16 FETCH cycles, then ERR
    for (int k = 0; k < 16; k++) begin
      check("to_req", 32'(imem_req), 32'd1);
      check("to_err_low", 32'(fetch_err), 32'd0);
      @(negedge clk); #1;
    end
    check("to_err", 32'(fetch_err), 32'd1);
    check("to_req_off", 32'(imem_req), 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'h12345678;
    @(negedge clk); #1;
    imem_ack = 1'b0;
    check("to_sticky", 32'(fetch_err), 32'd1);
    check("to_late_valid", 32'(instr_valid), 32'd0);
    check("to_late_count", fetch_count, 32'd0);
    check("to_late_instr", instr, 32'd0);

    // Reset mid-FETCH
    reset = 1'b0; #1;
    pc_in = RESET_PC;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #1;
    do_fetch(32'h00400020, 32'h20080005, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h00400024, 32'd1);
    check("mid_req_before", 32'(imem_req), 32'd1);
    reset = 1'b0; #1;
    check("mid_req", 32'(imem_req), 32'd0);
    check("mid_valid", 32'(instr_valid), 32'd0);
    check("mid_count", fetch_count, 32'd0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #1;
    check("restart_addr", imem_addr, 32'h00400024);
    do_fetch(32'h00400024, 32'hAC090000, 1, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h00400028, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
